ecc_wr_sched: RTL and testbench
===============================

// Module: ecc_wr_sched
// PURPOSE
//  Write scheduler in front of the ecc_enc Hamming SECDED encoder (8b data -> 13b codeword {p[4:0],d[7:0]}).
//  Arbitrates two write requesters (host port, background scrub port) onto one encoder and one MRAM array port.
//  Sequences each write through SETUP / PULSE / RECOVER timing and reports completion.
//  Sits between the host write path / scrubber and the MRAM macro pins.
// PARAMETERS
//  AW        10  MRAM word address width
//  SETUP_CYC 1   cycles cs high, we low, before write pulse (0 = skip state)
//  WR_CYC    4   write-pulse length in cycles (we high); must be >=1, elaboration error otherwise
//  REC_CYC   2   recovery cycles, cs/we low, before done (0 = skip state)
// PORTS
//  clk_i        in   1   single clock, all logic rising-edge
//  rst_i        in   1   synchronous, active-high reset
//  host_req_i   in   1   host write request; hold with addr/data until host_gnt_o
//  host_addr_i  in   AW  host write address
//  host_data_i  in   8   host write data
//  host_gnt_o   out  1   1-cycle accept strobe for host (combinational, IDLE only)
//  scrb_req_i   in   1   scrub write request; same rules as host
//  scrb_addr_i  in   AW  scrub write address
//  scrb_data_i  in   8   scrub write data (already corrected)
//  scrb_gnt_o   out  1   1-cycle accept strobe for scrub
//  mram_cs_o    out  1   MRAM chip select
//  mram_we_o    out  1   MRAM write enable (pulse)
//  mram_addr_o  out  AW  registered write address
//  mram_wdata_o out  13  registered encoded codeword
//  busy_o       out  1   high in any state except IDLE
//  done_o       out  1   1-cycle pulse, write finished
//  done_src_o   out  1   source of finished write: 0 host, 1 scrub; valid with done_o
// BEHAVIOUR
//  - Reset: state IDLE; all outputs 0; RR pointer = host preferred; counters 0.
//  - States: IDLE -> SETUP -> PULSE -> RECOV -> DONE -> IDLE; SETUP/RECOV skipped when param is 0.
//  - IDLE: if any req, exactly one gnt high same cycle; at that edge capture addr, src,
//    and ecc_enc(muxed data) into mram_addr_o / mram_wdata_o. No gnt outside IDLE.
//  - Arbitration: round robin; on simultaneous req the port not granted last wins;
//    single req always wins. Pointer updates only on grant.
//  - SETUP: cs=1, we=0 for SETUP_CYC cycles. PULSE: cs=1, we=1 for exactly WR_CYC cycles.
//  - RECOV: cs=0, we=0 for REC_CYC cycles. DONE: done_o=1 one cycle, done_src_o=captured src.
//  - addr/wdata held stable from grant edge through DONE; change only on next grant.
//  - Period per write = 2+SETUP_CYC+WR_CYC+REC_CYC cycles (defaults: 9); first we high
//    SETUP_CYC+1 cycles after gnt cycle.
//  - Down-counter width $clog2(max(SETUP_CYC,WR_CYC,REC_CYC)+1); reload on each state entry.
//  - Req dropped before gnt: no effect. Req changes after gnt: ignored (data already captured).
//  - rst_i mid-write: next edge forces IDLE, cs/we low, no done_o; write is lost.
// STRUCTURE
//  - Shared package ecc_pkg: DATA_W=8, CW_W=13, state encoding localparams, SRC_HOST/SRC_SCRB.
//  - Instantiates ecc_enc (combinational) on granted data mux; optional sub-module rr_arb2
//    (2-way round-robin arbiter, combinational gnt + registered pointer).
// TESTING
//  - Host d=0x01 addr=0x005, defaults -> wdata=0x1301, we high 4 cycles, done_o src=0 at gnt+8.
//  - Scrub d=0xFF -> wdata=0x03FF; d=0x00 -> 0x0000; cs low during RECOV, 2 cycles.
//  - Both req every cycle from reset -> grants alternate host,scrub,host,...; 9-cycle period.
//  - Req asserted while busy: no gnt until IDLE; granted in IDLE cycle following DONE.
//  - rst_i during PULSE cycle 2 -> we/cs 0 next edge, no done_o, next req granted normally.
//  - SETUP_CYC=0, REC_CYC=0 build: we high at gnt+1, done at gnt+1+WR_CYC.

Source files
------------

// File: rtl/ecc_pkg.sv
// rtl/ecc_pkg.sv - shared widths, source ids and scheduler state type for the ECC write path
package ecc_pkg;
    localparam int DATA_W = 8;
    localparam int PAR_W  = 5;
    localparam int CW_W   = DATA_W + PAR_W;

    localparam logic SRC_HOST = 1'b0;
    localparam logic SRC_SCRB = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_RECOV = 3'd3,
        ST_DONE  = 3'd4
    } state_t;
endpackage

// File: rtl/ecc_enc.sv
// rtl/ecc_enc.sv - combinational Hamming SECDED encoder, codeword {p[4:0], d[7:0]}
module ecc_enc
    import ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CW_W-1:0]   cw_o
);
    logic [PAR_W-1:0] par;

    // p[3:0] are Hamming checks for positions 1,2,4,8; p[4] is overall parity of the whole word
    always_comb begin
        par    = '0;
        par[0] = data_i[0] ^ data_i[1] ^ data_i[3] ^ data_i[4] ^ data_i[6];
        par[1] = data_i[0] ^ data_i[2] ^ data_i[3] ^ data_i[5] ^ data_i[6];
        par[2] = data_i[1] ^ data_i[2] ^ data_i[3] ^ data_i[7];
        par[3] = data_i[4] ^ data_i[5] ^ data_i[6] ^ data_i[7];
        par[4] = (^data_i) ^ par[0] ^ par[1] ^ par[2] ^ par[3];
        cw_o   = {par, data_i};
    end
endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin arbiter, combinational grant, registered preference
module rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);
    logic ptr_q;
    logic ptr_d;

    // ptr_q high means requester 1 is preferred on a tie
    always_comb begin
        gnt_o = 2'b00;
        if (en_i) begin
            if (req_i == 2'b11) begin
                gnt_o = ptr_q ? 2'b10 : 2'b01;
            end else begin
                gnt_o = req_i;
            end
        end
        ptr_d = ptr_q;
        if (gnt_o[0]) begin
            ptr_d = 1'b1;
        end else if (gnt_o[1]) begin
            ptr_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/ecc_wr_sched.sv
// rtl/ecc_wr_sched.sv - arbitrates host/scrub writes, encodes data and sequences MRAM write timing
module ecc_wr_sched
    import ecc_pkg::*;
#(
    parameter int AW        = 10,
    parameter int SETUP_CYC = 1,
    parameter int WR_CYC    = 4,
    parameter int REC_CYC   = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              host_req_i,
    input  logic [AW-1:0]     host_addr_i,
    input  logic [DATA_W-1:0] host_data_i,
    output logic              host_gnt_o,
    input  logic              scrb_req_i,
    input  logic [AW-1:0]     scrb_addr_i,
    input  logic [DATA_W-1:0] scrb_data_i,
    output logic              scrb_gnt_o,
    output logic              mram_cs_o,
    output logic              mram_we_o,
    output logic [AW-1:0]     mram_addr_o,
    output logic [CW_W-1:0]   mram_wdata_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              done_src_o
);
    localparam int MAX_SW  = (SETUP_CYC > WR_CYC) ? SETUP_CYC : WR_CYC;
    localparam int MAX_CYC = (MAX_SW > REC_CYC) ? MAX_SW : REC_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    if (WR_CYC < 1) begin : g_bad_wr_cyc
        $error("ecc_wr_sched: WR_CYC must be at least 1");
    end

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [CW_W-1:0]   wdata_q, wdata_d;
    logic              src_q, src_d;
    logic              cs_q, cs_d, we_q, we_d;
    logic              busy_q, busy_d, done_q, done_d, dsrc_q, dsrc_d;
    logic [1:0]        gnt;
    logic [DATA_W-1:0] mux_data;
    logic [CW_W-1:0]   enc_cw;

    rr_arb2 u_arb (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (state_q == ST_IDLE),
        .req_i ({scrb_req_i, host_req_i}),
        .gnt_o (gnt)
    );

    assign mux_data = gnt[1] ? scrb_data_i : host_data_i;

    ecc_enc u_enc (
        .data_i (mux_data),
        .cw_o   (enc_cw)
    );

    // Each timed state reloads cnt with its length-1 on entry and exits when cnt reaches 0
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        src_d   = src_q;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    addr_d  = gnt[1] ? scrb_addr_i : host_addr_i;
                    wdata_d = enc_cw;
                    src_d   = gnt[1] ? SRC_SCRB : SRC_HOST;
                    if (SETUP_CYC > 0) begin
                        state_d = ST_SETUP;
                        cnt_d   = CNT_W'(SETUP_CYC - 1);
                    end else begin
                        state_d = ST_PULSE;
                        cnt_d   = CNT_W'(WR_CYC - 1);
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = CNT_W'(WR_CYC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    if (REC_CYC > 0) begin
                        state_d = ST_RECOV;
                        cnt_d   = CNT_W'(REC_CYC - 1);
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RECOV: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        cs_d   = (state_d == ST_SETUP) || (state_d == ST_PULSE);
        we_d   = (state_d == ST_PULSE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
        dsrc_d = (state_d == ST_DONE) ? src_d : 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            src_q   <= SRC_HOST;
            cs_q    <= 1'b0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dsrc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            src_q   <= src_d;
            cs_q    <= cs_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dsrc_q  <= dsrc_d;
        end
    end

    assign host_gnt_o   = gnt[0];
    assign scrb_gnt_o   = gnt[1];
    assign mram_cs_o    = cs_q;
    assign mram_we_o    = we_q;
    assign mram_addr_o  = addr_q;
    assign mram_wdata_o = wdata_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign done_src_o   = dsrc_q;
endmodule

// File: tb/tb_ecc_wr_sched.sv
// tb/tb_ecc_wr_sched.sv - self-checking bench for ecc_wr_sched against a timeline reference model
module tb_ecc_wr_sched;
    localparam int S = 1, W = 4, R = 2;
    localparam int P = 2 + S + W + R;

    logic        clk, rst;
    logic        host_req, scrb_req;
    logic [9:0]  host_addr, scrb_addr;
    logic [7:0]  host_data, scrb_data;
    logic        host_gnt, scrb_gnt, cs, we, busy, done, done_src;
    logic [9:0]  maddr;
    logic [12:0] wdata;

    logic        d2_req;
    logic [9:0]  d2_addr;
    logic [7:0]  d2_data;
    logic        d2_sreq;
    logic [9:0]  d2_saddr;
    logic [7:0]  d2_sdata;
    logic        d2_gnt, d2_sgnt, d2_cs, d2_we, d2_busy, d2_done, d2_dsrc;
    logic [9:0]  d2_maddr;
    logic [12:0] d2_wdata;

    int n_chk = 0, n_fail = 0;
    int cyc = 0;
    bit chk_en = 0;
    bit last_hg = 0, last_sg = 0;

    bit          m_active = 0;
    int          m_g = 0;
    bit          m_src = 0;
    bit          m_pref_scrb = 0;
    logic [9:0]  m_addr = '0;
    logic [12:0] m_cw = '0;

    ecc_wr_sched dut (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(host_req), .host_addr_i(host_addr), .host_data_i(host_data), .host_gnt_o(host_gnt),
        .scrb_req_i(scrb_req), .scrb_addr_i(scrb_addr), .scrb_data_i(scrb_data), .scrb_gnt_o(scrb_gnt),
        .mram_cs_o(cs), .mram_we_o(we), .mram_addr_o(maddr), .mram_wdata_o(wdata),
        .busy_o(busy), .done_o(done), .done_src_o(done_src)
    );

    ecc_wr_sched #(.AW(10), .SETUP_CYC(0), .WR_CYC(4), .REC_CYC(0)) dut_fast (
        .clk_i(clk), .rst_i(rst),
        .host_req_i(d2_req), .host_addr_i(d2_addr), .host_data_i(d2_data), .host_gnt_o(d2_gnt),
        .scrb_req_i(d2_sreq), .scrb_addr_i(d2_saddr), .scrb_data_i(d2_sdata), .scrb_gnt_o(d2_sgnt),
        .mram_cs_o(d2_cs), .mram_we_o(d2_we), .mram_addr_o(d2_maddr), .mram_wdata_o(d2_wdata),
        .busy_o(d2_busy), .done_o(d2_done), .done_src_o(d2_dsrc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Textbook Hamming placement: data in non-power-of-two positions 1..12, check bit k covers positions with bit k set
    function automatic logic [12:0] ref_enc(input logic [7:0] d);
        logic [12:1] pos;
        logic [4:0]  p;
        int          k;
        pos = '0;
        p   = '0;
        k   = 0;
        for (int i = 1; i <= 12; i++) begin
            if ((i & (i - 1)) != 0) begin
                pos[i] = d[k];
                k++;
            end
        end
        for (int b = 0; b < 4; b++)
            for (int i = 1; i <= 12; i++)
                if (((i >> b) & 1) == 1) p[b] = p[b] ^ pos[i];
        p[4] = (^d) ^ (^p[3:0]);
        return {p, d};
    endfunction

    // Reference timeline: offset o after the grant cycle -> SETUP 1..S, PULSE S+1..S+W, RECOV, DONE at P-1
    always @(negedge clk) begin
        int o;
        bit in_w, eh, es, edone;
        cyc++;
        o     = cyc - m_g;
        in_w  = m_active && (o >= 1) && (o <= P - 1);
        eh    = 1'b0;
        es    = 1'b0;
        if (!in_w) begin
            if (host_req && scrb_req) begin
                es = m_pref_scrb;
                eh = !m_pref_scrb;
            end else begin
                eh = host_req;
                es = scrb_req;
            end
        end
        edone = in_w && (o == P - 1);
        if (chk_en) begin
            chk("host_gnt", host_gnt, eh);
            chk("scrb_gnt", scrb_gnt, es);
            chk("busy", busy, in_w);
            chk("cs", cs, in_w && (o <= S + W));
            chk("we", we, in_w && (o > S) && (o <= S + W));
            chk("done", done, edone);
            chk("done_src", done_src, edone && m_src);
            chk("addr", maddr, m_addr);
            chk("wdata", wdata, m_cw);
        end
        last_hg = host_gnt;
        last_sg = scrb_gnt;
        if (rst) begin
            m_active    = 0;
            m_pref_scrb = 0;
            m_src       = 0;
            m_addr      = '0;
            m_cw        = '0;
        end else if (eh || es) begin
            m_active    = 1;
            m_g         = cyc;
            m_src       = es;
            m_addr      = es ? scrb_addr : host_addr;
            m_cw        = ref_enc(es ? scrb_data : host_data);
            m_pref_scrb = eh;
        end
    end

    task automatic dir_write(input bit scrb, input logic [9:0] a, input logic [7:0] d,
                             input logic [12:0] exp_cw);
        bit got;
        int t, we_n, rec_n, done_at;
        logic dsrc;
        @(posedge clk); #1;
        if (scrb) begin scrb_req = 1; scrb_addr = a; scrb_data = d; end
        else      begin host_req = 1; host_addr = a; host_data = d; end
        got = 0;
        t   = 0;
        while (!got && t < 30) begin
            @(negedge clk);
            got = scrb ? scrb_gnt : host_gnt;
            t++;
        end
        chk("dir_gnt", got, 1);
        @(posedge clk); #1;
        host_req = 0;
        scrb_req = 0;
        we_n = 0; rec_n = 0; done_at = -1; dsrc = 1'bx;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) chk("dir_cw", wdata, exp_cw);
            if (we) we_n++;
            if (busy && !cs && !done) rec_n++;
            if (done) begin done_at = k; dsrc = done_src; end
        end
        chk("dir_we_len", we_n, W);
        chk("dir_recov_len", rec_n, R);
        chk("dir_done_at", done_at, P - 1);
        chk("dir_done_src", dsrc, scrb);
    endtask

    initial begin
        bit got, dn, prev;
        int t, n, prevk, we_n, we_first, done_at;
        rst = 1; host_req = 0; scrb_req = 0;
        host_addr = '0; host_data = '0; scrb_addr = '0; scrb_data = '0;
        d2_req = 0; d2_addr = '0; d2_data = '0; d2_sreq = 0; d2_saddr = '0; d2_sdata = '0;
        repeat (3) @(posedge clk);
        #1 chk_en = 1;
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_cs", cs, 0);
        chk("rst_done", done, 0);
        chk("rst_wdata", wdata, 0);
        @(posedge clk); #1 rst = 0;

        dir_write(0, 10'h005, 8'h01, 13'h1301);
        dir_write(1, 10'h3FF, 8'hFF, 13'h03FF);
        dir_write(1, 10'h100, 8'h00, 13'h0000);

        // Both requesters held from reset: host first, then strict alternation every P cycles
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 rst = 0;
        host_req = 1; host_addr = 10'h011; host_data = 8'hA5;
        scrb_req = 1; scrb_addr = 10'h022; scrb_data = 8'h3C;
        n = 0; prev = 0; prevk = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (host_gnt || scrb_gnt) begin
                chk("alt_src", scrb_gnt, (n == 0) ? 1'b0 : !prev);
                if (n > 0) chk("alt_period", k - prevk, P);
                prev = scrb_gnt;
                prevk = k;
                n++;
            end
        end
        chk("alt_count", n, 6);
        @(posedge clk); #1 host_req = 0; scrb_req = 0;
        repeat (12) @(posedge clk);

        // Reset during the second pulse cycle kills the write
        #1 host_req = 1; host_addr = 10'h155; host_data = 8'h77;
        got = 0; t = 0;
        while (!got && t < 30) begin @(negedge clk); got = host_gnt; t++; end
        chk("rstp_gnt", got, 1);
        @(posedge clk); #1 host_req = 0;
        @(posedge clk);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("rstp_we_before", we, 1);
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        chk("rstp_cs_after", cs, 0);
        chk("rstp_we_after", we, 0);
        chk("rstp_busy_after", busy, 0);
        dn = 0;
        repeat (10) begin @(negedge clk); dn = dn | done; end
        chk("rstp_no_done", dn, 0);
        dir_write(0, 10'h2AA, 8'hC3, ref_enc(8'hC3));

        // Random traffic with occasional withdrawn requests and resets
        for (int c = 0; c < 1500; c++) begin
            @(posedge clk); #1;
            rst = 0;
            if (host_req && (last_hg || $urandom_range(0, 30) == 0)) host_req = 0;
            if (scrb_req && (last_sg || $urandom_range(0, 30) == 0)) scrb_req = 0;
            if (!host_req && $urandom_range(0, 2) == 0) begin
                host_req  = 1;
                host_addr = 10'($urandom_range(0, 1023));
                host_data = 8'($urandom_range(0, 255));
            end
            if (!scrb_req && $urandom_range(0, 3) == 0) begin
                scrb_req  = 1;
                scrb_addr = 10'($urandom_range(0, 1023));
                scrb_data = 8'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 250) == 0) begin
                rst = 1; host_req = 0; scrb_req = 0;
            end
        end
        @(posedge clk); #1 rst = 0; host_req = 0; scrb_req = 0;
        repeat (12) @(posedge clk);

        // Build without setup/recovery states
        #1 d2_req = 1; d2_addr = 10'h3A5; d2_data = 8'h5A;
        got = 0; t = 0;
        while (!got && t < 30) begin @(negedge clk); got = d2_gnt; t++; end
        chk("fast_gnt", got, 1);
        @(posedge clk); #1 d2_req = 0;
        we_n = 0; we_first = -1; done_at = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) chk("fast_cw", d2_wdata, ref_enc(8'h5A));
            if (k == 1) chk("fast_addr", d2_maddr, 10'h3A5);
            if (d2_we) begin we_n++; if (we_first < 0) we_first = k; end
            if (d2_done) done_at = k;
        end
        chk("fast_we_first", we_first, 1);
        chk("fast_we_len", we_n, 4);
        chk("fast_done_at", done_at, 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
